tb_domain_reset_sequencer: RTL and testbench
============================================

# tb_domain_reset_sequencer

Clock-domain reset sequencer for the simulation testbench infrastructure. After the global asynchronous reset, it releases N per-domain resets in a staggered boot order. It then serves runtime reset requests from test components, granting one domain at a time in round-robin order. Each granted domain goes through a gate-clock / assert-reset / ungate / hold / release sequence. Its outputs drive per-domain reset lines and clock-disable controls of the testbench clock generator.

## Interface
- N, 4: number of clock/reset domains, ≥1
- ASSERT_CYCLES, 5: cycles a domain reset is held with its clock running, ≥1
- GAP_CYCLES, 2: cycles between successive domain releases during boot, ≥1
- tb_clk  in  1  sequencer clock; all outputs registered on its rising edge
- tb_aresetn  in  1  reset, asynchronous, active-low
- req  in  N  level request for a reset of domain j; held until ack[j]
- ack  out  N  one-cycle pulse; domain j sequence complete
- dom_reset  out  N  active-high reset to domain j
- clk_disable  out  N  1 = clock of domain j stopped
- busy  out  1  1 whenever state ≠ IDLE
- boot_done  out  1  1 once boot release has finished; cleared only by tb_aresetn

## Operation
- **Reset values (tb_aresetn=0, applied asynchronously):**
  - dom_reset all 1, clk_disable all 0, ack 0, busy 1, boot_done 0.
  - State BOOT, counter 0, domain index 0, RR pointer N-1, so domain 0 has the highest priority first.
- **States:** BOOT, IDLE, GATE, ASSERT, HOLD, ACK.
- **BOOT:**
  - Counter runs from the first tb_clk edge with tb_aresetn=1.
  - dom_reset[0] clears after ASSERT_CYCLES; each subsequent dom_reset[k] clears GAP_CYCLES later.
  - After dom_reset[N-1] clears: boot_done=1, go to IDLE.
  - req is ignored during BOOT; requests are level, so none are lost.
- **IDLE:** if any req bit is set, grant the first set bit searching from pointer+1 upward, wrapping. Pointer ← granted index. Go to GATE.
- **GATE:** clk_disable[g]=1 → ASSERT.
- **ASSERT:** dom_reset[g]=1 → HOLD.
- **HOLD:**
  - On entry: clk_disable[g]=0, counter cleared.
  - After ASSERT_CYCLES edges: dom_reset[g]=0, ack[g]=1 → ACK.
- **ACK:** ack cleared → IDLE.
- Only domain g is ever touched by a runtime sequence. No other domain's outputs change.
- req[g] dropped mid-sequence: the sequence completes and ack still pulses. No abort.
- req[g] still high after ack: treated as a new request and re-arbitrated normally.
- tb_aresetn asserted in any state: immediate return to reset values. Any in-progress sequence is discarded without ack. Full boot reruns after release.
- Counter width: $clog2(max(ASSERT_CYCLES, GAP_CYCLES)+1). It saturates and never wraps.

## Timing
- **Boot:** edge 1 is the first rising edge after tb_aresetn deasserts.
  - dom_reset[k] falls after edge ASSERT_CYCLES + k·GAP_CYCLES.
  - boot_done rises and busy falls on the same edge as dom_reset[N-1] falls.
- **Runtime sequence:** E is the IDLE edge that samples req.
  - clk_disable[g] high after edges E, E+1; low after E+2.
  - dom_reset[g] high after E+1 through E+1+ASSERT_CYCLES; low after E+2+ASSERT_CYCLES.
  - ack[g] high for exactly the cycle after edge E+2+ASSERT_CYCLES.
  - IDLE re-entered after E+3+ASSERT_CYCLES; the earliest next grant edge is E+4+ASSERT_CYCLES.
- Reset and clock are never both changing on the same edge for a domain.
- dom_reset is asserted only while its clock is stopped, and released only while its clock runs.

## Test plan
(N=4, ASSERT_CYCLES=5, GAP_CYCLES=2.)
- **Boot:** release tb_aresetn, req=0.
  - dom_reset[0..3] fall after edges 5, 7, 9, 11.
  - boot_done=1 and busy=0 from edge 11; clk_disable stays 0.
- **Single request:** req=4'b0100 held, sampled at edge E.
  - clk_disable[2] high after E..E+1.
  - dom_reset[2] high after E+1..E+6.
  - ack=4'b0100 for one cycle after E+7.
  - Domains 0, 1, 3 unchanged.
- **Round robin:** req=4'b1011 held, each bit dropped on its ack.
  - Grants in order 0, 1, 3, grant edges 9 cycles apart.
  - Then req=4'b1001: grant 0 before 3, since the pointer is at 3.
- **Request during boot:** req[1]=1 at edge 2.
  - No clk_disable/ack activity before boot_done.
  - Grant on the first IDLE edge (edge 12); ack[1] after edge 19.
- **Reset mid-HOLD:** tb_aresetn=0 two cycles into HOLD for domain 3.
  - Immediately: dom_reset=4'b1111, clk_disable=0, ack=0, boot_done=0.
  - After release: the full boot sequence repeats, then the still-held req[3] is served.
- **Request dropped:** req[0] pulsed for one cycle, sampled in IDLE.
  - Full sequence runs and ack[0] pulses once.
  - No second grant.

Source files
------------

// File: rtl/tb_domain_reset_sequencer.sv
// tb_domain_reset_sequencer: staggered boot release of N domain resets, then round-robin runtime reset sequences
module tb_domain_reset_sequencer #(
  parameter int N             = 4,
  parameter int ASSERT_CYCLES = 5,
  parameter int GAP_CYCLES    = 2
) (
  input  logic         tb_clk,
  input  logic         tb_aresetn,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] ack_o,
  output logic [N-1:0] dom_reset_o,
  output logic [N-1:0] clk_disable_o,
  output logic         busy_o,
  output logic         boot_done_o
);
  localparam int MC = ASSERT_CYCLES > GAP_CYCLES ? ASSERT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MC + 1);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] A_END = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] G_END = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  typedef enum logic [2:0] {BOOT, IDLE, GATE, ASSERT, HOLD, ACK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, gnt, k;
  logic [N-1:0] rst_q, rst_d, dis_q, dis_d, ack_q, ack_d;
  logic done_q, done_d, hit;
  // round-robin pick: first requesting domain above the pointer, wrapping
  always_comb begin
    hit = 1'b0;
    gnt = ptr_q;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr_q) + i) % N);
      if (!hit && req_i[k]) begin
        hit = 1'b1;
        gnt = k;
      end
    end
  end
  // next-state and output register values; the pointer doubles as the granted domain
  always_comb begin
    state_d = state_q;
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    idx_d = idx_q;
    ptr_d = ptr_q;
    rst_d = rst_q;
    dis_d = dis_q;
    ack_d = '0;
    done_d = done_q;
    case (state_q)
      BOOT: if (cnt_q == (idx_q == '0 ? A_END : G_END)) begin
        rst_d[idx_q] = 1'b0;
        cnt_d = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: if (hit) begin
        ptr_d = gnt;
        dis_d[gnt] = 1'b1;
        state_d = GATE;
      end
      GATE: begin
        rst_d[ptr_q] = 1'b1;
        state_d = ASSERT;
      end
      ASSERT: begin
        dis_d[ptr_q] = 1'b0;
        cnt_d = '0;
        state_d = HOLD;
      end
      HOLD: if (cnt_q == A_END) begin
        rst_d[ptr_q] = 1'b0;
        ack_d[ptr_q] = 1'b1;
        state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = BOOT;
    endcase
  end
  // state and output registers, returned to the boot condition by the async reset
  always_ff @(posedge tb_clk or negedge tb_aresetn) begin
    if (!tb_aresetn) begin
      state_q <= BOOT;
      cnt_q <= '0;
      idx_q <= '0;
      ptr_q <= LAST;
      rst_q <= '1;
      dis_q <= '0;
      ack_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      rst_q <= rst_d;
      dis_q <= dis_d;
      ack_q <= ack_d;
      done_q <= done_d;
    end
  end
  assign ack_o = ack_q;
  assign dom_reset_o = rst_q;
  assign clk_disable_o = dis_q;
  assign busy_o = state_q != IDLE;
  assign boot_done_o = done_q;
endmodule

// File: tb/tb_tb_domain_reset_sequencer.sv
// tb_tb_domain_reset_sequencer: scoreboard bench with an edge-arithmetic reference model
module tb_tb_domain_reset_sequencer;
  localparam int N = 4;
  localparam int A = 5;
  localparam int G = 2;
  localparam int BE = A + (N - 1) * G;
  logic tb_clk, tb_aresetn;
  logic [N-1:0] req_i, ack_o, dom_reset_o, clk_disable_o, exp_rst, exp_dis;
  logic busy_o, boot_done_o;
  typedef struct {int d; int t;} ev_t;
  ev_t q[$];
  ev_t ev;
  int e, next_free, cur_g, cur_e, ptr, checks, fails;
  tb_domain_reset_sequencer #(.N(N), .ASSERT_CYCLES(A), .GAP_CYCLES(G)) dut (
    .tb_clk(tb_clk), .tb_aresetn(tb_aresetn), .req_i(req_i), .ack_o(ack_o),
    .dom_reset_o(dom_reset_o), .clk_disable_o(clk_disable_o), .busy_o(busy_o), .boot_done_o(boot_done_o)
  );
  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s edge=%0d act=%0h exp=%0h", nm, e, act, exp);
    end
  endtask
  // reference model: e counts edges since reset release; grants computed from arbitration rules
  initial forever begin
    @(posedge tb_clk or negedge tb_aresetn);
    if (!tb_aresetn) begin
      e = 0;
      next_free = BE + 1;
      cur_e = -1000;
      cur_g = 0;
      ptr = N - 1;
      q.delete();
    end else begin
      e++;
      if (e >= next_free && req_i != 0) begin
        for (int i = 1; i <= N; i++)
          if (req_i[(ptr + i) % N]) begin
            cur_g = (ptr + i) % N;
            break;
          end
        ptr = cur_g;
        cur_e = e;
        next_free = e + A + 4;
        q.push_back('{cur_g, e + A + 2});
      end
    end
  end
  // monitor: level checks every cycle, scoreboard pop on every ack
  initial forever begin
    @(negedge tb_clk or negedge tb_aresetn);
    #1;
    for (int j = 0; j < N; j++) begin
      exp_rst[j] = (e < A + j * G) || (j == cur_g && e >= cur_e + 1 && e <= cur_e + 1 + A);
      exp_dis[j] = j == cur_g && e >= cur_e && e <= cur_e + 1;
    end
    chk("dom_reset", int'(dom_reset_o), int'(exp_rst));
    chk("clk_disable", int'(clk_disable_o), int'(exp_dis));
    chk("ack_level", int'(ack_o), e == cur_e + A + 2 ? 1 << cur_g : 0);
    chk("boot_done", int'(boot_done_o), int'(e >= BE));
    chk("busy", int'(busy_o), int'(e < BE || (e >= cur_e && e <= cur_e + A + 2)));
    if (ack_o != 0) begin
      if (q.size() == 0) chk("ack_unexpected", int'(ack_o), 0);
      else begin
        ev = q.pop_front();
        chk("ack_dom", int'(ack_o), 1 << ev.d);
        chk("ack_edge", e, ev.t);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge tb_clk);
    #3;
  endtask
  task automatic wait_ack_drop(input int lim);
    int n = 0;
    do begin
      @(negedge tb_clk);
      #1;
      n++;
    end while (ack_o == 0 && n < lim);
    if (ack_o == 0) chk("ack_timeout", 0, 1);
    #2 req_i = req_i & ~ack_o;
  endtask
  initial begin
    int n;
    checks = 0;
    fails = 0;
    tb_aresetn = 1'b0;
    req_i = '0;
    cyc(3);
    tb_aresetn = 1'b1;
    cyc(14);
    req_i = 4'b0100;
    wait_ack_drop(50);
    cyc(3);
    req_i = 4'b1011;
    repeat (3) wait_ack_drop(50);
    req_i = 4'b1001;
    repeat (2) wait_ack_drop(50);
    cyc(2);
    tb_aresetn = 1'b0;
    cyc(2);
    tb_aresetn = 1'b1;
    cyc(1);
    req_i = 4'b0010;
    wait_ack_drop(60);
    cyc(3);
    req_i = 4'b1000;
    n = 0;
    do begin
      @(negedge tb_clk);
      n++;
    end while (!clk_disable_o[3] && n < 20);
    if (!clk_disable_o[3]) chk("grant3_timeout", 0, 1);
    repeat (3) @(negedge tb_clk);
    cyc(1);
    tb_aresetn = 1'b0;
    cyc(2);
    tb_aresetn = 1'b1;
    wait_ack_drop(60);
    cyc(3);
    req_i = 4'b0001;
    cyc(1);
    req_i = '0;
    cyc(20);
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) req_i = N'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        tb_aresetn = 1'b0;
        cyc(1);
        tb_aresetn = 1'b1;
      end
      cyc(1);
    end
    req_i = '0;
    cyc(20);
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
